// File: rtl/spi_adc_responder.sv
// spi_adc_responder: MCP3202-style SPI responder that stands in for a
// 2-channel 12-bit ADC. All SPI pins are oversampled in the clk domain.
// Frame: [leading 0s] START SGL ODD MSBF | NULL | D11..D0 | tail zero.
module spi_adc_responder #(
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [DATA_BITS-1:0] ch0_value,
    input  logic [DATA_BITS-1:0] ch1_value,
    output logic                 conv_done,
    output logic                 conv_channel,
    output logic [DATA_BITS-1:0] conv_data,
    output logic                 frame_error
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CFG,
        ST_NULL,
        ST_DATA,
        ST_TAIL,
        ST_DONE
    } state_t;

    // Unsigned difference clamped at zero instead of wrapping.
    function automatic logic [DATA_BITS-1:0] sat_sub(
        input logic [DATA_BITS-1:0] a,
        input logic [DATA_BITS-1:0] b
    );
        return (a >= b) ? (a - b) : '0;
    endfunction

    // Conversion result for a given SGL/ODD command.
    function automatic logic [DATA_BITS-1:0] pick_sample(
        input logic                 sgl,
        input logic                 odd,
        input logic [DATA_BITS-1:0] c0,
        input logic [DATA_BITS-1:0] c1
    );
        logic [DATA_BITS-1:0] r;
        if (sgl) begin
            r = odd ? c1 : c0;
        end else begin
            r = odd ? sat_sub(c1, c0) : sat_sub(c0, c1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;
    // Tracks when the chains hold real pin samples rather than reset values.
    logic [SYNC_STAGES:0]   fill_q;
    logic                   armed_q;
    logic                   armed_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;
    // A frame may only start after cs_n has genuinely been seen high since
    // reset, so a reset with cs_n held low does not launch a new frame.
    assign cs_fall  = armed_q & ~cs_s & cs_dly_q;

    // Sticky arm flag: set once a real high level of cs_n has been seen.
    assign armed_d = armed_q | (fill_q[SYNC_STAGES] & cs_s);

    // Pin synchronizers, edge-detect delay taps and the arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_dly_q   <= sck_s;
            cs_dly_q    <= cs_s;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            armed_q     <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [1:0]           cfg_cnt_q, cfg_cnt_d;
    logic                 sgl_q, sgl_d;
    logic                 odd_q, odd_d;
    logic                 chan_q, chan_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 miso_q, miso_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 conv_chan_q, conv_chan_d;
    logic [DATA_BITS-1:0] conv_data_q, conv_data_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_cnt_q   <= '0;
            sgl_q       <= 1'b0;
            odd_q       <= 1'b0;
            chan_q      <= 1'b0;
            sample_q    <= '0;
            idx_q       <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            conv_chan_q <= 1'b0;
            conv_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            sgl_q       <= sgl_d;
            odd_q       <= odd_d;
            chan_q      <= chan_d;
            sample_q    <= sample_d;
            idx_q       <= idx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            conv_chan_q <= conv_chan_d;
            conv_data_q <= conv_data_d;
        end
    end

    // Next-state and output decode; cs_n rise overrides any SCK edge.
    always_comb begin
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        sgl_d       = sgl_q;
        odd_d       = odd_q;
        chan_d      = chan_q;
        sample_d    = sample_q;
        idx_d       = idx_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        conv_chan_d = conv_chan_q;
        conv_data_d = conv_data_q;

        if (cs_rise) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            if ((state_q == ST_CFG) || (state_q == ST_NULL) || (state_q == ST_DATA)) begin
                err_d = 1'b1;
            end
        end else if (!cs_s) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    // Leading zeros are skipped until the start bit.
                    if (sck_rise && mosi_s) begin
                        state_d   = ST_CFG;
                        cfg_cnt_d = '0;
                    end
                end
                ST_CFG: begin
                    if (sck_rise) begin
                        cfg_cnt_d = cfg_cnt_q + 2'd1;
                        case (cfg_cnt_q)
                            2'd0:    sgl_d = mosi_s;
                            2'd1:    odd_d = mosi_s;
                            default: begin
                                // Third bit is MSBF; output order is fixed
                                // MSB-first so the bit is not kept.
                                sample_d = pick_sample(sgl_q, odd_q, ch0_value, ch1_value);
                                chan_d   = odd_q;
                                state_d  = ST_NULL;
                            end
                        endcase
                    end
                end
                ST_NULL: begin
                    if (sck_fall) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        idx_d   = IDX_W'(DATA_BITS - 1);
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sck_fall) begin
                        miso_d = sample_q[idx_q];
                        if (idx_q == '0) begin
                            state_d = ST_TAIL;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    if (sck_fall) begin
                        miso_d      = 1'b0;
                        done_d      = 1'b1;
                        conv_data_d = sample_q;
                        conv_chan_d = chan_q;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Hold miso low until cs_n releases the frame.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign conv_done    = done_q;
    assign conv_channel = conv_chan_q;
    assign conv_data    = conv_data_q;
    assign frame_error  = err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Testbench for spi_adc_responder: directed SPI frames with a scoreboard of
// expected conversions and frame errors, checked by independent monitors.
module tb_spi_adc_responder;

    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [11:0] ch0_value = '0;
    logic [11:0] ch1_value = '0;
    logic        conv_done;
    logic        conv_channel;
    logic [11:0] conv_data;
    logic        frame_error;

    typedef struct {
        logic        chan;
        logic [11:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          err_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] rx_word = '0;
    logic        rx_null = 1'b0;

    spi_adc_responder #(.DATA_BITS(12), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .ch0_value    (ch0_value),
        .ch1_value    (ch1_value),
        .conv_done    (conv_done),
        .conv_channel (conv_channel),
        .conv_data    (conv_data),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One SPI frame: ncmd command bits (MSB of cmd first), ncyc SCK cycles
    // in total. ch0_value is changed to chg_val at cycle chg_cyc.
    task automatic spi_frame(input logic [15:0] cmd, input int ncmd, input int ncyc,
                             input bit raise_cs, input int chg_cyc, input logic [11:0] chg_val);
        logic [11:0] w;
        w = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int c = 0; c < ncyc; c++) begin
            spi_mosi = (c < ncmd) ? cmd[ncmd-1-c] : 1'b0;
            if (c == chg_cyc) ch0_value = chg_val;
            repeat (HALF) @(negedge clk);
            if (c == ncmd) rx_null = spi_miso;
            else if (c > ncmd && c <= ncmd + 12) w = {w[10:0], spi_miso};
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        rx_word = w;
        repeat (HALF) @(negedge clk);
        if (raise_cs) begin
            spi_cs_n = 1'b1;
            repeat (3 * HALF) @(negedge clk);
        end
    endtask

    task automatic expect_conv(input logic chan, input logic [11:0] data);
        exp_t e;
        e.chan = chan;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Conversion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (conv_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_conv_done: got pulse, expected none (data 0x%0h)", conv_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("conv_channel", 32'(conv_channel), 32'(e.chan));
                    chk("conv_data", 32'(conv_data), 32'(e.data));
                    chk("miso_word", 32'(rx_word), 32'(e.data));
                    chk("miso_null_bit", 32'(rx_null), 32'd0);
                end
                @(negedge clk);
                chk("conv_done_width", 32'(conv_done), 32'd0);
            end
        end
    end

    // Frame-error monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_error) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_error: got pulse, expected none");
                end else begin
                    void'(err_q.pop_front());
                    chk("oe_on_abort", 32'(spi_miso_oe), 32'd0);
                    chk("miso_on_abort", 32'(spi_miso), 32'd0);
                end
                @(negedge clk);
                chk("frame_error_width", 32'(frame_error), 32'd0);
            end
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_oe", 32'(spi_miso_oe), 32'd0);
        chk("rst_conv_done", 32'(conv_done), 32'd0);
        chk("rst_conv_channel", 32'(conv_channel), 32'd0);
        chk("rst_conv_data", 32'(conv_data), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single-ended CH0.
        ch0_value = 12'hA5C;
        expect_conv(1'b0, 12'hA5C);
        spi_frame(16'b1101, 4, 17, 1'b1, -1, '0);

        // Single-ended CH1 with three leading zeros.
        ch1_value = 12'h0FF;
        expect_conv(1'b1, 12'h0FF);
        spi_frame(16'b0001111, 7, 20, 1'b1, -1, '0);

        // Differential, saturating and positive.
        ch0_value = 12'h100;
        ch1_value = 12'h300;
        expect_conv(1'b0, 12'h000);
        spi_frame(16'b1001, 4, 17, 1'b1, -1, '0);
        expect_conv(1'b1, 12'h200);
        spi_frame(16'b1011, 4, 17, 1'b1, -1, '0);

        // Abort after five data bits.
        ch0_value = 12'h555;
        err_q.push_back(1);
        spi_frame(16'b1101, 4, 9, 1'b1, -1, '0);
        chk("abort_keeps_data", 32'(conv_data), 32'h200);
        chk("abort_keeps_channel", 32'(conv_channel), 32'd1);
        expect_conv(1'b0, 12'h555);
        spi_frame(16'b1101, 4, 17, 1'b1, -1, '0);

        // Source change during DATA does not affect shifted value.
        ch0_value = 12'h123;
        expect_conv(1'b0, 12'h123);
        spi_frame(16'b1101, 4, 17, 1'b1, 7, 12'hFFF);
        chk("ch0_changed", 32'(ch0_value), 32'hFFF);

        // Reset mid-DATA with cs_n held low.
        ch1_value = 12'hABC;
        spi_frame(16'b1111, 4, 8, 1'b0, -1, '0);
        chk("pre_rst_oe", 32'(spi_miso_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_miso", 32'(spi_miso), 32'd0);
        chk("midrst_oe", 32'(spi_miso_oe), 32'd0);
        chk("midrst_conv_data", 32'(conv_data), 32'd0);
        chk("midrst_frame_error", 32'(frame_error), 32'd0);
        repeat (HALF) @(negedge clk);
        for (int c = 0; c < 17; c++) begin
            spi_mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            chk("held_low_oe", 32'(spi_miso_oe), 32'd0);
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        expect_conv(1'b1, 12'hABC);
        spi_frame(16'b1111, 4, 17, 1'b1, -1, '0);

        repeat (50) @(negedge clk);
        chk("conv_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("error_queue_drained", 32'(err_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
